// File: rtl/dense_layer_sequencer.sv
// Sequencer for one fully-connected layer: per output neuron it loads the bias,
// multiply-accumulates IN_DATA_NUM activation/weight pairs, then writes f(acc).
module dense_layer_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int IN_DATA_NUM  = 8,
  parameter int OUT_DATA_NUM = 4,
  parameter int FRAC_BITS    = 8,
  parameter int RELU         = 1,
  localparam int IA_W = $clog2(IN_DATA_NUM),
  localparam int WA_W = $clog2(IN_DATA_NUM * OUT_DATA_NUM),
  localparam int BA_W = (OUT_DATA_NUM > 1) ? $clog2(OUT_DATA_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  done,
  output logic                  busy,
  output logic [IA_W-1:0]       in_adr,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [WA_W-1:0]       w_adr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [BA_W-1:0]       b_adr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic [BA_W-1:0]       out_adr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_wr
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = 2 * DATA_WIDTH + $clog2(IN_DATA_NUM) + 1;
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_BIAS = 3'd1,
    MAC       = 3'd2,
    DRAIN     = 3'd3,
    WRITE     = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t                    state;
  logic [BA_W-1:0]           outIdx;
  logic [IA_W-1:0]           inIdx;
  logic signed [ACC_W-1:0]   acc;
  logic signed [PROD_W-1:0]  prod;
  logic                      prodValid;
  logic signed [ACC_W-1:0]   prodExt;
  logic signed [ACC_W-1:0]   accSum;

  assign prodExt = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign accSum  = acc + prodExt;

  // Rescale, saturate to the data range, then optionally clamp negatives.
  function automatic logic [DATA_WIDTH-1:0] activate(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    logic [DATA_WIDTH-1:0]   r;
    s = a >>> FRAC_BITS;
    if (s > MAX_V) begin
      r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (s < MIN_V) begin
      r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      r = s[DATA_WIDTH-1:0];
    end
    if ((RELU != 0) && r[DATA_WIDTH-1]) begin
      r = '0;
    end else begin
      r = r;
    end
    return r;
  endfunction

  function automatic logic [WA_W-1:0] weightAddr(input logic [BA_W-1:0] o, input logic [IA_W-1:0] i);
    return WA_W'(o) * WA_W'(IN_DATA_NUM) + WA_W'(i);
  endfunction

  // Sequencer FSM; every output is registered so it lines up with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      outIdx    <= '0;
      inIdx     <= '0;
      acc       <= '0;
      prod      <= '0;
      prodValid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      in_adr    <= '0;
      w_adr     <= '0;
      b_adr     <= '0;
      out_adr   <= '0;
      out_data  <= '0;
      out_wr    <= 1'b0;
    end else begin
      done     <= 1'b0;
      out_wr   <= 1'b0;
      out_adr  <= '0;
      out_data <= '0;
      in_adr   <= '0;
      w_adr    <= '0;
      b_adr    <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= LOAD_BIAS;
            outIdx <= '0;
            busy   <= 1'b1;
          end else begin
            busy   <= 1'b0;
          end
        end
        LOAD_BIAS: begin
          acc       <= $signed({{(ACC_W-DATA_WIDTH){b_data[DATA_WIDTH-1]}}, b_data}) <<< FRAC_BITS;
          inIdx     <= '0;
          prodValid <= 1'b0;
          in_adr    <= '0;
          w_adr     <= weightAddr(outIdx, IA_W'(0));
          state     <= MAC;
        end
        MAC: begin
          prod      <= $signed({{DATA_WIDTH{in_data[DATA_WIDTH-1]}}, in_data})
                     * $signed({{DATA_WIDTH{w_data[DATA_WIDTH-1]}}, w_data});
          prodValid <= 1'b1;
          if (prodValid) begin
            acc <= accSum;
          end else begin
            acc <= acc;
          end
          if (inIdx == IA_W'(IN_DATA_NUM - 1)) begin
            state <= DRAIN;
          end else begin
            inIdx  <= inIdx + IA_W'(1);
            in_adr <= inIdx + IA_W'(1);
            w_adr  <= weightAddr(outIdx, inIdx + IA_W'(1));
          end
        end
        DRAIN: begin
          // The last product lands here, so the written value uses the summed accumulator.
          acc       <= accSum;
          prodValid <= 1'b0;
          out_wr    <= 1'b1;
          out_adr   <= outIdx;
          out_data  <= activate(accSum);
          state     <= WRITE;
        end
        WRITE: begin
          if (outIdx == BA_W'(OUT_DATA_NUM - 1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            outIdx <= outIdx + BA_W'(1);
            b_adr  <= outIdx + BA_W'(1);
            state  <= LOAD_BIAS;
          end
        end
        DONE: begin
          busy   <= 1'b0;
          outIdx <= '0;
          inIdx  <= '0;
          state  <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
